// File: rtl/level_sync_filt.sv
// Multi-bit level synchroniser with a per-bit stability filter and registered
// rise/fall strobes. Each channel is filtered independently.
module level_sync_filt #(
  parameter int   WIDTH      = 1,
  parameter int   STAGES     = 2,
  parameter logic INIT_STATE = 1'b0,
  parameter int   FILT_LEN   = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] async,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] busy
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("level_sync_filt: STAGES must be 2..4");
  end
  if (FILT_LEN < 1 || FILT_LEN > 65535) begin : g_bad_filt
    $error("level_sync_filt: FILT_LEN must be 1..65535");
  end

  (* ASYNC_REG = "TRUE", SHIFT_EXTRACT = "NO" *)
  logic [WIDTH-1:0] stage_q [STAGES];

  logic [WIDTH-1:0] s;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= {WIDTH{INIT_STATE}};
      end
    end else begin
      stage_q[0] <= async;
      for (int k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign s = stage_q[STAGES-1];

  // A channel only moves once the synchronised level has differed for FILT_LEN edges.
  always_comb begin
    sync_d = sync_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] == sync_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        sync_d[i] = s[i];
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {WIDTH{INIT_STATE}};
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sync = sync_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = s ^ sync_q;

endmodule
